// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, arbiter state type and overflow helper
// Purpose: shared definitions for alu_share_arbiter and its round-robin picker.
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] AF_ADD     = 4'b0000;
    localparam logic [3:0] AF_ADDU    = 4'b0001;
    localparam logic [3:0] AF_SUB     = 4'b0010;
    localparam logic [3:0] AF_SUBU    = 4'b0011;
    localparam logic [3:0] AF_AND     = 4'b0100;
    localparam logic [3:0] AF_OR      = 4'b0101;
    localparam logic [3:0] AF_XOR     = 4'b0110;
    localparam logic [3:0] AF_NOR_LUI = 4'b0111;
    localparam logic [3:0] AF_SLTU    = 4'b1010;
    localparam logic [3:0] AF_SLT     = 4'b1011;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Signed overflow from operand/result sign bits; only the signed add/sub codes can overflow.
    function automatic logic signed_ovf(input logic [3:0] af, input logic sa, input logic sb,
                                        input logic sr);
        case (af)
            AF_ADD:  return (sa == sb) && (sr != sa);
            AF_SUB:  return (sa != sb) && (sr != sa);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - combinational round-robin picker
// Purpose: grants the lowest-index request at or after ptr, wrapping modulo NREQ.
// Ports:
//   req        in  NREQ  request vector
//   ptr        in  PW    round-robin start index (0..NREQ-1)
//   grant      out NREQ  one-hot grant (0 when nothing requested)
//   any        out 1     at least one request present
//   grant_idx  out PW    index of the granted requester
module alu_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            any,
    output logic [PW-1:0]   grant_idx
);

    always_comb begin
        int k;
        k         = 0;
        grant     = '0;
        any       = 1'b0;
        grant_idx = '0;
        for (int n = 0; n < NREQ; n++) begin
            k = int'(ptr) + n;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!any && req[k]) begin
                any       = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = PW'(k);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between NREQ requesters
// Purpose: accepts one request at a time, drives the external ALU from latched operands,
//   registers the result (and optionally signed overflow) and returns it to the requester.
// Configuration: define ALU_ARB_OVF_EN to register signed add/sub overflow on rsp_ovf;
//   otherwise rsp_ovf is tied to 0.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake (req_ready one-hot pulse)
//   req_a, req_b, req_af, req_i  packed per-requester operands, function code, immediate flag
//   alu_srca/srcb/af/i         latched operands to the ALU
//   alu_res                    ALU result
//   rsp_valid/rsp_ready        per-requester response handshake (rsp_valid one-hot)
//   rsp_data, rsp_ovf          registered result and overflow flag
//   busy                       arbiter is not idle
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_af,
    input  logic [NREQ-1:0]   req_i,
    output logic [W-1:0]      alu_srca,
    output logic [W-1:0]      alu_srcb,
    output logic [3:0]        alu_af,
    output logic              alu_i,
    input  logic [W-1:0]      alu_res,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_ovf,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t     state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]     af_q, af_d;
    logic           i_q, i_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] grant;
    logic            any;
    logic [PW-1:0]   grant_idx;

    alu_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .any       (any),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        af_d       = af_q;
        i_d        = i_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        rsp_valid  = '0;
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    req_ready = grant;
                    a_d       = req_a[grant_idx*W +: W];
                    b_d       = req_b[grant_idx*W +: W];
                    af_d      = req_af[grant_idx*4 +: 4];
                    i_d       = req_i[grant_idx];
                    owner_d   = grant_idx;
                    state_d   = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rsp_data_d = alu_res;
                state_d    = ARB_RESP;
            end
            ARB_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                // Only the owner's ready bit completes the response.
                if (rsp_ready[owner_q]) begin
                    rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            af_q       <= '0;
            i_q        <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            af_q       <= af_d;
            i_q        <= i_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef ALU_ARB_OVF_EN
    logic rsp_ovf_q, rsp_ovf_d;

    always_comb begin
        rsp_ovf_d = rsp_ovf_q;
        if (state_q == ARB_EXEC) begin
            rsp_ovf_d = signed_ovf(af_q, a_q[W-1], b_q[W-1], alu_res[W-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf_q <= 1'b0;
        end else begin
            rsp_ovf_q <= rsp_ovf_d;
        end
    end

    assign rsp_ovf = rsp_ovf_q;
`else
    assign rsp_ovf = 1'b0;
`endif

    // ALU inputs always reflect the latches so they never glitch between operations.
    assign alu_srca = a_q;
    assign alu_srcb = b_q;
    assign alu_af   = af_q;
    assign alu_i    = i_q;
    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;
`ifdef ALU_ARB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ*4-1:0] req_af;
    logic [NREQ-1:0]   req_i;
    logic [W-1:0]      alu_srca, alu_srcb, alu_res;
    logic [3:0]        alu_af;
    logic              alu_i;
    logic [NREQ-1:0]   rsp_valid, rsp_ready;
    logic [W-1:0]      rsp_data;
    logic              rsp_ovf, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_af(req_af), .req_i(req_i),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_af(alu_af), .alu_i(alu_i),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] af, input logic i,
                                            input logic [31:0] a, input logic [31:0] b);
        case (af)
            4'd0, 4'd1: return a + b;
            4'd2, 4'd3: return a - b;
            4'd4:       return a & b;
            4'd5:       return a | b;
            4'd6:       return a ^ b;
            4'd7:       return i ? {b[15:0], 16'h0000} : ~(a | b);
            4'd10:      return (a < b) ? 32'd1 : 32'd0;
            4'd11:      return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:    return 32'd0;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_af, alu_i, alu_srca, alu_srcb);

    // Overflow as "true signed sum/difference does not fit in 32 bits".
    function automatic logic exp_ovf(input logic [3:0] af, input logic [31:0] a,
                                     input logic [31:0] b);
        longint s;
        if (af == 4'd0)      s = longint'($signed(a)) + longint'($signed(b));
        else if (af == 4'd2) s = longint'($signed(a)) - longint'($signed(b));
        else                 return 1'b0;
        return OVF_EN && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_af    = '0;
        req_i     = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one request on requester k and collects the response; checks are left to callers.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] af, input logic i, output int lat,
                          output logic [31:0] data, output logic ovf, output logic ok);
        int c;
        ok = 1'b1; lat = -1; data = '0; ovf = 1'b0; c = 0;
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        req_af[k*4 +: 4] = af;
        req_i[k] = i;
        req_valid[k] = 1'b1;
        #1;
        while (!req_ready[k] && c < 20) begin
            @(posedge clk); #1; c++;
        end
        if (!req_ready[k]) begin
            req_valid[k] = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        c = 1;
        while (!rsp_valid[k] && c < 20) begin
            @(posedge clk); #1; c++;
        end
        if (!rsp_valid[k]) begin
            ok = 1'b0;
            return;
        end
        lat  = c;
        data = rsp_data;
        ovf  = rsp_ovf;
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            n_checks++;
            if ({rsp_valid, busy, req_ready} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d rsp_valid=%b busy=%b req_ready=%b required all 0",
                         cyc, rsp_valid, busy, req_ready);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({alu_srca, alu_srcb, alu_af, alu_i, rsp_data, rsp_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_latches srca=%h srcb=%h af=%h i=%b data=%h ovf=%b required 0",
                     alu_srca, alu_srcb, alu_af, alu_i, rsp_data, rsp_ovf);
        end
        // Reset during EXEC must drop the operation without a response.
        req_a[0 +: W] = 32'd1; req_b[0 +: W] = 32'd2; req_af[3:0] = 4'd0;
        req_valid[0] = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL midexec_accept req_ready=%b required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midexec_busy busy=%b required 1", busy);
        end
        rst_n = 1'b0; #2; rst_n = 1'b1;
        c = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) c++;
        end
        n_checks++;
        if (c != 0) begin
            n_fail++;
            $display("FAIL midexec_drop bad_cycles=%0d required 0", c);
        end
    endtask

    task automatic test_basic_add();
        int lat; logic [31:0] d; logic o, ok;
        run_op(0, 32'd5, 32'd7, 4'd0, 1'b0, lat, d, o, ok);
        n_checks++;
        if (!ok || lat != 2 || d !== 32'd12 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_add ok=%b lat=%0d data=%h ovf=%b required ok=1 lat=2 data=0000000c ovf=0",
                     ok, lat, d, o);
        end
    endtask

    task automatic test_round_robin();
        int ptr, w, c;
        logic [31:0] exp_d;
        logic [NREQ-1:0] exp_g;
        do_reset();
        req_a[0 +: W] = 32'd1; req_b[0 +: W] = 32'd2; req_af[3:0] = 4'd0;
        req_a[W +: W] = 32'd3; req_b[W +: W] = 32'd5; req_af[7:4] = 4'd2;
        req_valid = 2'b11;
        ptr = 0;
        for (int g = 0; g < 4; g++) begin
            w = -1;
            for (int off = 0; off < NREQ; off++) begin
                if (w < 0 && req_valid[(ptr + off) % NREQ]) w = (ptr + off) % NREQ;
            end
            exp_g = '0;
            exp_g[w] = 1'b1;
            #1; c = 0;
            while (req_ready == '0 && c < 10) begin @(posedge clk); #1; c++; end
            n_checks++;
            if (req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL rr_grant n=%0d req_ready=%b required %b", g, req_ready, exp_g);
            end
            @(posedge clk); #1;
            c = 0;
            while (rsp_valid == '0 && c < 10) begin @(posedge clk); #1; c++; end
            exp_d = alu_fn(req_af[w*4 +: 4], 1'b0, req_a[w*W +: W], req_b[w*W +: W]);
            if (w == 1) exp_d = 32'hFFFF_FFFE;
            n_checks++;
            if (rsp_valid !== exp_g || rsp_data !== exp_d) begin
                n_fail++;
                $display("FAIL rr_resp n=%0d rsp_valid=%b data=%h required %b %h",
                         g, rsp_valid, rsp_data, exp_g, exp_d);
            end
            rsp_ready = exp_g;
            @(posedge clk); #1;
            rsp_ready = '0;
            if (g == 3) req_valid = '0;
            ptr = (w + 1) % NREQ;
        end
    endtask

    task automatic test_backpressure();
        int bad;
        req_a[0 +: W] = 32'h10; req_b[0 +: W] = 32'h20; req_af[3:0] = 4'd0; req_i[0] = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_accept req_ready=%b required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b1;
        bad = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (rsp_valid !== 2'b01 || rsp_data !== 32'h30 || req_ready !== 2'b00) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0 || rsp_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_hold bad_cycles=%0d rsp_valid=%b required 0 and 01", bad, rsp_valid);
        end
        rsp_ready = 2'b01;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rsp_ready = '0;
        n_checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release rsp_valid=%b busy=%b required 00 0", rsp_valid, busy);
        end
    endtask

    task automatic test_ovf();
        int lat; logic [31:0] d; logic o, ok;
        logic [31:0] ta [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] tb [3] = '{32'h1, 32'h1, 32'h1};
        logic [3:0]  tf [3] = '{4'd0, 4'd1, 4'd2};
        logic        eo [3] = '{OVF_EN, 1'b0, OVF_EN};
        for (int n = 0; n < 3; n++) begin
            run_op(1, ta[n], tb[n], tf[n], 1'b0, lat, d, o, ok);
            n_checks++;
            if (!ok || o !== eo[n] || o !== exp_ovf(tf[n], ta[n], tb[n]) ||
                d !== alu_fn(tf[n], 1'b0, ta[n], tb[n])) begin
                n_fail++;
                $display("FAIL ovf n=%0d ok=%b data=%h ovf=%b required ovf=%b", n, ok, d, o, eo[n]);
            end
        end
    endtask

    task automatic test_alu_ops();
        int lat; logic [31:0] d; logic o, ok;
        run_op(0, 32'hFFFF_FFFF, 32'h1, 4'd11, 1'b0, lat, d, o, ok);
        n_checks++;
        if (!ok || d !== 32'd1) begin
            n_fail++; $display("FAIL slt data=%h required 00000001", d);
        end
        run_op(1, 32'hFFFF_FFFF, 32'h1, 4'd10, 1'b0, lat, d, o, ok);
        n_checks++;
        if (!ok || d !== 32'd0) begin
            n_fail++; $display("FAIL sltu data=%h required 00000000", d);
        end
        run_op(0, 32'h0, 32'h0000_ABCD, 4'd7, 1'b1, lat, d, o, ok);
        n_checks++;
        if (!ok || d !== 32'hABCD_0000) begin
            n_fail++; $display("FAIL lui data=%h required abcd0000", d);
        end
    endtask

    task automatic test_random();
        int lat, k; logic [31:0] a, b, d; logic [3:0] af; logic i, o, ok;
        logic [3:0] codes [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                   4'd10, 4'd11, 4'd15, 4'd8};
        logic [31:0] edges [4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int n = 0; n < 40; n++) begin
            k  = int'($urandom_range(0, NREQ - 1));
            af = codes[$urandom_range(0, 11)];
            i  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            run_op(k, a, b, af, i, lat, d, o, ok);
            n_checks++;
            if (!ok || lat != 2 || d !== alu_fn(af, i, a, b) || o !== exp_ovf(af, a, b)) begin
                n_fail++;
                $display("FAIL random n=%0d k=%0d af=%h a=%h b=%h ok=%b lat=%0d data=%h ovf=%b required data=%h ovf=%b",
                         n, k, af, a, b, ok, lat, d, o, alu_fn(af, i, a, b), exp_ovf(af, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_round_robin();
        test_backpressure();
        test_ovf();
        test_alu_ops();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
